// File: rtl/hit_address_issuer.sv
// Buffers raw hit addresses in a small FIFO and issues them to the hit store as paced
// newAddress pulses; at end of event drains the FIFO and raises a one-cycle readMemory request.
module hit_address_issuer #(
    parameter int unsigned ROWINDEXBITS = 4,
    parameter int unsigned COLINDEXBITS = 4,
    parameter int unsigned MEMNROWS     = 16,
    parameter int unsigned FIFODEPTH    = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 hitValid,
    input  logic [ROWINDEXBITS+COLINDEXBITS-1:0] hitAddress,
    output logic                                 hitReady,
    input  logic                                 eventDone,
    input  logic                                 storageReady,
    output logic                                 newAddress,
    output logic [ROWINDEXBITS-1:0]              wordIndex,
    output logic [COLINDEXBITS-1:0]              letterIndex,
    output logic                                 readMemory,
    output logic                                 busy,
    output logic [7:0]                           droppedCount
);

    localparam int unsigned ADDRBITS = ROWINDEXBITS + COLINDEXBITS;
    localparam int unsigned PTRBITS  = $clog2(FIFODEPTH);
    localparam logic [PTRBITS:0] DEPTHCOUNT = FIFODEPTH[PTRBITS:0];

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] HOLDOFF = 3'd2;
    localparam logic [2:0] DRAIN   = 3'd3;
    localparam logic [2:0] READREQ = 3'd4;

    logic [2:0]          state;
    logic [2:0]          stateNext;
    logic [ADDRBITS-1:0] fifoMem [FIFODEPTH];
    logic [PTRBITS-1:0]  wrPtr;
    logic [PTRBITS-1:0]  rdPtr;
    logic [PTRBITS:0]    count;
    logic                srPrev;
    logic                eventPending;

    logic fifoFull;
    logic fifoEmpty;
    logic accept;
    logic inRange;
    logic push;
    logic pop;
    logic issueOk;
    logic eventSeen;
    logic readDone;

    assign fifoFull  = (count == DEPTHCOUNT);
    assign fifoEmpty = (count == '0);
    assign hitReady  = !fifoFull && (state != READREQ);
    assign accept    = hitValid && hitReady;
    assign inRange   = ({{(32-ROWINDEXBITS){1'b0}}, hitAddress[ADDRBITS-1 -: ROWINDEXBITS]}
                        < MEMNROWS);
    assign push      = accept && inRange;
    // Storage must have shown ready for two consecutive cycles before it takes anything.
    assign issueOk   = storageReady && srPrev;
    assign pop       = ((state == ISSUE) || (state == DRAIN)) && !fifoEmpty && issueOk;
    assign eventSeen = eventPending || eventDone;
    assign readDone  = (state == READREQ) && issueOk;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (eventSeen) begin
                    stateNext = (push || !fifoEmpty) ? DRAIN : READREQ;
                end else if (push || !fifoEmpty) begin
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                if (pop) begin
                    stateNext = HOLDOFF;
                end else if (eventSeen) begin
                    stateNext = DRAIN;
                end else if (fifoEmpty && !push) begin
                    stateNext = IDLE;
                end
            end
            HOLDOFF: stateNext = eventSeen ? DRAIN : ISSUE;
            DRAIN: begin
                if (pop) begin
                    stateNext = HOLDOFF;
                end else if (fifoEmpty && !push) begin
                    stateNext = READREQ;
                end
            end
            READREQ: begin
                if (issueOk) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifoMem[wrPtr] <= hitAddress;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wrPtr        <= '0;
            rdPtr        <= '0;
            count        <= '0;
            srPrev       <= 1'b0;
            eventPending <= 1'b0;
            newAddress   <= 1'b0;
            wordIndex    <= '0;
            letterIndex  <= '0;
            readMemory   <= 1'b0;
            busy         <= 1'b0;
            droppedCount <= '0;
        end else begin
            state      <= stateNext;
            srPrev     <= storageReady;
            newAddress <= pop;
            readMemory <= readDone;

            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr       <= rdPtr + 1'b1;
                wordIndex   <= fifoMem[rdPtr][ADDRBITS-1 -: ROWINDEXBITS];
                letterIndex <= fifoMem[rdPtr][COLINDEXBITS-1:0];
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end

            if (readDone) begin
                eventPending <= 1'b0;
            end else if (eventDone) begin
                eventPending <= 1'b1;
            end

            if (readDone) begin
                busy <= 1'b0;
            end else if (push || eventDone) begin
                busy <= 1'b1;
            end

            if (accept && !inRange && (droppedCount != 8'hFF)) begin
                droppedCount <= droppedCount + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_hit_address_issuer.sv
// Directed-vector bench for hit_address_issuer; instance built with MEMNROWS=12 so that
// rows 12..15 exercise the out-of-range drop path.
module tb_hit_address_issuer;

    logic       clock = 1'b0;
    logic       reset;
    logic       hitValid;
    logic [7:0] hitAddress;
    logic       hitReady;
    logic       eventDone;
    logic       storageReady;
    logic       newAddress;
    logic [3:0] wordIndex;
    logic [3:0] letterIndex;
    logic       readMemory;
    logic       busy;
    logic [7:0] droppedCount;

    int errCount   = 0;
    int checkCount = 0;
    int naCount    = 0;
    int rmCount    = 0;
    int naBase;
    int rmBase;
    logic found;

    always #5 clock = ~clock;

    hit_address_issuer #(
        .ROWINDEXBITS(4),
        .COLINDEXBITS(4),
        .MEMNROWS    (12),
        .FIFODEPTH   (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .hitValid    (hitValid),
        .hitAddress  (hitAddress),
        .hitReady    (hitReady),
        .eventDone   (eventDone),
        .storageReady(storageReady),
        .newAddress  (newAddress),
        .wordIndex   (wordIndex),
        .letterIndex (letterIndex),
        .readMemory  (readMemory),
        .busy        (busy),
        .droppedCount(droppedCount)
    );

    // Pulses are one cycle wide, so sampling mid-cycle counts each exactly once.
    always @(negedge clock) begin
        if (newAddress === 1'b1) naCount <= naCount + 1;
        if (readMemory === 1'b1) rmCount <= rmCount + 1;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic doReset;
        reset      = 1'b1;
        hitValid   = 1'b0;
        hitAddress = 8'h00;
        eventDone  = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkVal({tag, "_newAddress"}, 32'(newAddress), 0);
        checkVal({tag, "_readMemory"}, 32'(readMemory), 0);
        checkVal({tag, "_busy"}, 32'(busy), 0);
        checkVal({tag, "_wordIndex"}, 32'(wordIndex), 0);
        checkVal({tag, "_letterIndex"}, 32'(letterIndex), 0);
        checkVal({tag, "_droppedCount"}, 32'(droppedCount), 0);
        checkVal({tag, "_hitReady"}, 32'(hitReady), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        storageReady = 1'b0;
        doReset();
        checkResetState("reset");

        // T1: back-to-back hits with storage ready, issue every other cycle
        storageReady = 1'b1;
        step();
        hitValid = 1'b1; hitAddress = 8'h23;
        step();
        checkVal("t1_na_n1", 32'(newAddress), 0);
        checkVal("t1_ready_n1", 32'(hitReady), 1);
        hitAddress = 8'h23;
        step();
        checkVal("t1_na_n2", 32'(newAddress), 1);
        checkVal("t1_word_a", 32'(wordIndex), 2);
        checkVal("t1_letter_a", 32'(letterIndex), 3);
        checkVal("t1_ready_n2", 32'(hitReady), 1);
        hitAddress = 8'h5F;
        step();
        checkVal("t1_na_n3", 32'(newAddress), 0);
        hitValid = 1'b0;
        step();
        checkVal("t1_na_n4", 32'(newAddress), 1);
        checkVal("t1_word_b", 32'(wordIndex), 2);
        checkVal("t1_letter_b", 32'(letterIndex), 3);
        step();
        checkVal("t1_na_n5", 32'(newAddress), 0);
        step();
        checkVal("t1_na_n6", 32'(newAddress), 1);
        checkVal("t1_word_c", 32'(wordIndex), 5);
        checkVal("t1_letter_c", 32'(letterIndex), 15);
        step();
        checkVal("t1_na_n7", 32'(newAddress), 0);
        checkVal("t1_busy", 32'(busy), 1);

        // T2: storage stalled, FIFO fills at 4, then drains in order
        storageReady = 1'b0;
        doReset();
        for (int k = 0; k < 6; k++) begin
            hitValid = 1'b1; hitAddress = 8'(16 + k);
            checkVal($sformatf("t2_ready_%0d", k), 32'(hitReady), (k < 4) ? 1 : 0);
            step();
            checkVal($sformatf("t2_na_stall_%0d", k), 32'(newAddress), 0);
        end
        hitValid = 1'b0; storageReady = 1'b1;
        for (int j = 0; j < 8; j++) begin
            step();
            checkVal($sformatf("t2_na_%0d", j), 32'(newAddress), 32'(j % 2));
            if (j % 2 == 1) begin
                checkVal($sformatf("t2_word_%0d", j), 32'(wordIndex), 1);
                checkVal($sformatf("t2_letter_%0d", j), 32'(letterIndex), 32'(j / 2));
            end
        end
        checkVal("t2_ready_after", 32'(hitReady), 1);

        // T3: out-of-range rows are dropped and counted, counter saturates
        storageReady = 1'b1;
        doReset();
        naBase = naCount;
        hitValid = 1'b1; hitAddress = 8'hC1;
        step();
        hitAddress = 8'hF0;
        step();
        hitValid = 1'b0;
        step();
        step();
        checkVal("t3_dropped_2", 32'(droppedCount), 2);
        checkVal("t3_no_issue", 32'(naCount - naBase), 0);
        hitValid = 1'b1; hitAddress = 8'hE5;
        for (int k = 0; k < 298; k++) step();
        hitValid = 1'b0;
        step();
        checkVal("t3_dropped_sat", 32'(droppedCount), 255);
        checkVal("t3_no_issue_sat", 32'(naCount - naBase), 0);

        // T4: three hits then eventDone -> three issues, one readMemory
        storageReady = 1'b1;
        doReset();
        step();
        naBase = naCount; rmBase = rmCount;
        hitValid = 1'b1; hitAddress = 8'h31;
        step();
        hitAddress = 8'h32;
        step();
        hitAddress = 8'h33;
        step();
        hitValid = 1'b0; eventDone = 1'b1;
        step();
        eventDone = 1'b0;
        checkVal("t4_busy_during", 32'(busy), 1);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (readMemory === 1'b1) begin
                found = 1'b1;
                checkVal("t4_busy_at_read", 32'(busy), 0);
                checkVal("t4_issues_before_read", 32'(naCount - naBase), 3);
                break;
            end
        end
        checkVal("t4_read_seen", 32'(found), 1);
        step();
        checkVal("t4_read_one_cycle", 32'(readMemory), 0);
        repeat (5) step();
        checkVal("t4_read_count", 32'(rmCount - rmBase), 1);
        checkVal("t4_issue_count", 32'(naCount - naBase), 3);

        // T5: storageReady 1,0,1,1 -> issue only after two consecutive ready cycles
        storageReady = 1'b0;
        doReset();
        hitValid = 1'b1; hitAddress = 8'h44;
        step();
        hitValid = 1'b0;
        checkVal("t5_na_0", 32'(newAddress), 0);
        storageReady = 1'b1; step();
        checkVal("t5_na_1", 32'(newAddress), 0);
        storageReady = 1'b0; step();
        checkVal("t5_na_2", 32'(newAddress), 0);
        storageReady = 1'b1; step();
        checkVal("t5_na_3", 32'(newAddress), 0);
        step();
        checkVal("t5_na_4", 32'(newAddress), 1);
        checkVal("t5_word", 32'(wordIndex), 4);
        checkVal("t5_letter", 32'(letterIndex), 4);

        // T6: reset with hits queued and an event pending discards everything
        storageReady = 1'b0;
        doReset();
        hitValid = 1'b1; hitAddress = 8'hE0;
        step();
        hitAddress = 8'h21; step();
        hitAddress = 8'h22; step();
        hitAddress = 8'h23; step();
        hitValid = 1'b0; eventDone = 1'b1;
        step();
        eventDone = 1'b0;
        checkVal("t6_dropped_pre", 32'(droppedCount), 1);
        checkVal("t6_busy_pre", 32'(busy), 1);
        reset = 1'b1;
        #2;
        checkResetState("t6_async");
        step();
        reset = 1'b0; storageReady = 1'b1;
        naBase = naCount; rmBase = rmCount;
        repeat (10) step();
        checkVal("t6_no_issue", 32'(naCount - naBase), 0);
        checkVal("t6_no_read", 32'(rmCount - rmBase), 0);
        checkVal("t6_busy_post", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
